// File: rtl/ltc2333_pkg.sv
// Shared types and field layout for the LTC2333 readout path.
package ltc2333_pkg;
  localparam int LTC2333_WORD_BITS = 24;
  localparam int RESULT_LSB        = 6;
  localparam int CHID_LSB          = 3;
  localparam int SPAN_LSB          = 0;

  typedef struct packed {
    logic [17:0] result;
    logic [2:0]  chid;
    logic [2:0]  span;
  } ltc2333_word_t;

  typedef enum logic {IDLE, SHIFT} rd_state_t;
endpackage

// File: rtl/ltc2333_sync_fifo.sv
// Single-clock FIFO; head entry is presented combinationally, zero when empty.
module ltc2333_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ltc2333_read.sv
// LTC2333 receive path: oversampled scko/sdo capture, per-cnv framing, AXI-Stream out.
module ltc2333_read
  import ltc2333_pkg::*;
#(
  parameter int N_WORDS     = 8,
  parameter int WORD_BITS   = LTC2333_WORD_BITS,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnv,
  input  logic                 scko,
  input  logic                 sdo,
  output logic [WORD_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 frame_err,
  output logic [15:0]          overflow_cnt,
  output logic [31:0]          frame_cnt
);
  localparam int BC_W = $clog2(WORD_BITS);
  localparam int WC_W = $clog2(N_WORDS) + 1;

  logic [SYNC_STAGES-1:0] cnv_sync_q, scko_sync_q, sdo_sync_q;
  logic                   cnv_d1_q, scko_d1_q;
  logic                   cnv_s, scko_s, sdo_s, cnv_rise, scko_rise;

  rd_state_t              state_q;
  logic [BC_W-1:0]        bit_cnt_q;
  logic [WC_W-1:0]        word_cnt_q;
  logic [WORD_BITS-2:0]   sreg_q;
  logic [WORD_BITS-1:0]   word_d;
  logic                   push_q, frame_err_q;
  logic [WORD_BITS:0]     push_data_q;
  logic [31:0]            frame_cnt_q;
  logic [15:0]            ovf_cnt_q;

  logic [WORD_BITS:0]     fifo_dout;
  logic                   fifo_empty, fifo_full, fifo_pop;

  assign cnv_s     = cnv_sync_q[SYNC_STAGES-1];
  assign scko_s    = scko_sync_q[SYNC_STAGES-1];
  assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
  assign cnv_rise  = cnv_s & ~cnv_d1_q;
  assign scko_rise = scko_s & ~scko_d1_q;
  assign word_d    = {sreg_q, sdo_s};

  // sdo shares the scko pipeline depth so the bit lines up with its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnv_sync_q  <= '0;
      scko_sync_q <= '0;
      sdo_sync_q  <= '0;
      cnv_d1_q    <= 1'b0;
      scko_d1_q   <= 1'b0;
    end else begin
      cnv_sync_q  <= {cnv_sync_q[SYNC_STAGES-2:0], cnv};
      scko_sync_q <= {scko_sync_q[SYNC_STAGES-2:0], scko};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], sdo};
      cnv_d1_q    <= cnv_s;
      scko_d1_q   <= scko_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      sreg_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cnv_rise) begin
            state_q    <= SHIFT;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            sreg_q     <= '0;
          end
        end
        SHIFT: begin
          // cnv wins over a coincident scko edge: the frame restarts.
          if (cnv_rise) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            sreg_q      <= '0;
          end else if (scko_rise) begin
            sreg_q <= word_d[WORD_BITS-2:0];
            if (bit_cnt_q == BC_W'(WORD_BITS - 1)) begin
              push_q      <= 1'b1;
              push_data_q <= {word_cnt_q == WC_W'(N_WORDS - 1), word_d};
              bit_cnt_q   <= '0;
              word_cnt_q  <= word_cnt_q + 1'b1;
              if (word_cnt_q == WC_W'(N_WORDS - 1)) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                state_q     <= IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_pop = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (push_q && fifo_full && !fifo_pop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  ltc2333_sync_fifo #(
    .WIDTH (WORD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .din_i   (push_data_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout[WORD_BITS-1:0];
  assign m_axis_tlast  = fifo_dout[WORD_BITS];
  assign frame_err     = frame_err_q;
  assign overflow_cnt  = ovf_cnt_q;
  assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_ltc2333_read.sv
// Bench for ltc2333_read: bit-level ADC model driving scko/sdo, scoreboard on the stream.
module tb_ltc2333_read;
  localparam int N_WORDS = 8, WORD_BITS = 24, FIFO_DEPTH = 16, SYNC_STAGES = 2;

  logic                 clk = 1'b0;
  logic                 rst, cnv, scko, sdo, m_axis_tready;
  logic [WORD_BITS-1:0] m_axis_tdata;
  logic                 m_axis_tvalid, m_axis_tlast, frame_err;
  logic [15:0]          overflow_cnt;
  logic [31:0]          frame_cnt;

  int tests_run = 0, failed = 0, err_cycles = 0;
  logic [WORD_BITS:0] exp_q[$], obs_q[$];
  logic [WORD_BITS:0] got, want;

  always #5 clk = ~clk;

  ltc2333_read #(
    .N_WORDS(N_WORDS), .WORD_BITS(WORD_BITS), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .cnv(cnv), .scko(scko), .sdo(sdo),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_err(frame_err), .overflow_cnt(overflow_cnt),
    .frame_cnt(frame_cnt)
  );

  // Beats are recorded on the falling edge preceding the accepting rising edge.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
    if (frame_err) err_cycles++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdo = b;
    wait_clk(4);
    scko = 1'b1;
    wait_clk(4);
    scko = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_BITS-1:0] d, input logic last, input bit keep);
    for (int i = WORD_BITS - 1; i >= 0; i--) send_bit(d[i]);
    if (keep) exp_q.push_back({last, d});
  endtask

  task automatic pulse_cnv();
    cnv = 1'b1;
    wait_clk(4);
    cnv = 1'b0;
    wait_clk(4);
  endtask

  function automatic logic [WORD_BITS-1:0] word_of(input logic [WORD_BITS-1:0] base,
                                                   input logic [WORD_BITS-1:0] step, input int w);
    return base + step * WORD_BITS'(w);
  endfunction

  task automatic send_frame(input logic [WORD_BITS-1:0] base, input logic [WORD_BITS-1:0] step,
                            input int keep_n);
    pulse_cnv();
    for (int w = 0; w < N_WORDS; w++)
      send_word(word_of(base, step, w), w == N_WORDS - 1, w < keep_n);
  endtask

  // Waits (bounded) for n beats, then a little longer so surplus beats show up too.
  task automatic drain(input int n);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 2000 && obs_q.size() < n; c++) wait_clk(1);
    wait_clk(20);
  endtask

  task automatic test_reset();
    rst = 1'b1; cnv = 1'b0; scko = 1'b0; sdo = 1'b0; m_axis_tready = 1'b0;
    wait_clk(3);
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_err} !== '0) begin
      failed++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h e=%b want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_err);
    end
    tests_run++;
    if (overflow_cnt !== 16'd0 || frame_cnt !== 32'd0) begin
      failed++;
      $display("FAIL reset_counters got ovf=%0d frames=%0d want 0 0", overflow_cnt, frame_cnt);
    end
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_frame();
    int e0 = err_cycles;
    m_axis_tready = 1'b1;
    send_frame(24'habcdef, 24'h0, N_WORDS);
    drain(N_WORDS);
    tests_run++;
    if (obs_q.size() != N_WORDS) begin
      failed++; $display("FAIL frame_beats got %0d want %0d", obs_q.size(), N_WORDS);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin failed++; $display("FAIL frame_word got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
    tests_run++;
    if (frame_cnt !== 32'd1 || err_cycles != e0) begin
      failed++; $display("FAIL frame_status got frames=%0d errs=%0d want 1 0", frame_cnt, err_cycles - e0);
    end
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    send_frame(24'h100000, 24'h000101, N_WORDS);
    send_frame(24'h200000, 24'h000203, N_WORDS);
    send_frame(24'h300000, 24'h000305, 0);
    wait_clk(10);
    tests_run++;
    if (overflow_cnt !== 16'd8 || frame_cnt !== 32'd4) begin
      failed++; $display("FAIL bp_counters got ovf=%0d frames=%0d want 8 4", overflow_cnt, frame_cnt);
    end
    drain(2 * N_WORDS);
    tests_run++;
    if (obs_q.size() != 2 * N_WORDS) begin
      failed++; $display("FAIL bp_beats got %0d want %0d", obs_q.size(), 2 * N_WORDS);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin failed++; $display("FAIL bp_word got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    int e0 = err_cycles;
    m_axis_tready = 1'b1;
    pulse_cnv();
    send_word(24'h5a5a17, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    pulse_cnv();
    for (int w = 0; w < N_WORDS; w++)
      send_word(word_of(24'h7c0011, 24'h010f09, w), w == N_WORDS - 1, 1'b1);
    drain(N_WORDS + 1);
    tests_run++;
    if (err_cycles - e0 != 1) begin
      failed++; $display("FAIL abort_err_cycles got %0d want 1", err_cycles - e0);
    end
    tests_run++;
    if (obs_q.size() != N_WORDS + 1 || frame_cnt !== 32'd5) begin
      failed++; $display("FAIL abort_beats got %0d frames=%0d want %0d 5", obs_q.size(), frame_cnt, N_WORDS + 1);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin failed++; $display("FAIL abort_word got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b0;
    pulse_cnv();
    for (int w = 0; w < 3; w++) send_word(word_of(24'h0f0f00, 24'h000011, w), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst = 1'b1;
    wait_clk(2);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || overflow_cnt !== 16'd0 || frame_cnt !== 32'd0) begin
      failed++;
      $display("FAIL rst_mid_state got v=%b ovf=%0d frames=%0d want 0 0 0", m_axis_tvalid, overflow_cnt, frame_cnt);
    end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    wait_clk(2);
    m_axis_tready = 1'b1;
    send_frame(24'h812345, 24'h020406, N_WORDS);
    drain(N_WORDS);
    tests_run++;
    if (obs_q.size() != N_WORDS || frame_cnt !== 32'd1) begin
      failed++; $display("FAIL rst_mid_beats got %0d frames=%0d want %0d 1", obs_q.size(), frame_cnt, N_WORDS);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin failed++; $display("FAIL rst_mid_word got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_idle_noise();
    logic [31:0] fc0 = frame_cnt;
    logic [15:0] ov0 = overflow_cnt;
    logic        seen = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      seen |= m_axis_tvalid;
    end
    wait_clk(10);
    tests_run++;
    if (seen || obs_q.size() != 0) begin
      failed++; $display("FAIL idle_valid got seen=%b beats=%0d want 0 0", seen, obs_q.size());
    end
    tests_run++;
    if (frame_cnt !== fc0 || overflow_cnt !== ov0) begin
      failed++; $display("FAIL idle_counters got %0d/%0d want %0d/%0d", frame_cnt, overflow_cnt, fc0, ov0);
    end
    obs_q.delete();
  endtask

  task automatic test_full_fifo();
    logic [WORD_BITS-1:0] x = 24'hc3a501;
    m_axis_tready = 1'b0;
    send_frame(24'h400000, 24'h001001, N_WORDS);
    send_frame(24'h500000, 24'h002003, N_WORDS);
    pulse_cnv();
    for (int i = WORD_BITS - 1; i >= 1; i--) send_bit(x[i]);
    sdo = x[0];
    wait_clk(4);
    scko = 1'b1;
    wait_clk(3);          // push lands on the next rising edge
    m_axis_tready = 1'b1;
    wait_clk(1);
    m_axis_tready = 1'b0;
    wait_clk(3);
    scko = 1'b0;
    exp_q.push_back({1'b0, x});
    tests_run++;
    if (overflow_cnt !== 16'd0) begin
      failed++; $display("FAIL full_push_pop_ovf got %0d want 0", overflow_cnt);
    end
    send_word(24'hdead01, 1'b0, 1'b0);
    wait_clk(4);
    tests_run++;
    if (overflow_cnt !== 16'd1) begin
      failed++; $display("FAIL full_still_full_ovf got %0d want 1", overflow_cnt);
    end
    m_axis_tready = 1'b1;
    for (int w = 2; w < N_WORDS; w++)
      send_word(word_of(24'h600000, 24'h000707, w), w == N_WORDS - 1, 1'b1);
    drain(2 * N_WORDS + N_WORDS - 1);
    tests_run++;
    if (obs_q.size() != 2 * N_WORDS + N_WORDS - 1 || frame_cnt !== 32'd4) begin
      failed++;
      $display("FAIL full_beats got %0d frames=%0d want %0d 4", obs_q.size(), frame_cnt, 3 * N_WORDS - 1);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin failed++; $display("FAIL full_word got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_idle_noise();
    test_full_fifo();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
